statem_monitor: RTL and testbench

STATEM_MONITOR -- requirements
Module: statem_monitor

---
 rtl/statem_monitor.sv | 130 +++++++++++++
 tb/tb_statem_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/statem_monitor.sv
// Protocol monitor for a four-state sequencer: decodes its one-hot-ish output code,
// flags illegal codes/transitions, infers the state-one branch input and counts cycles.
module statem_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       code_in,
    input  logic             code_vld,
    input  logic             err_clr,
    output logic             locked,
    output logic [1:0]       state_dec,
    output logic             in_est,
    output logic             in_est_vld,
    output logic             err,
    output logic [7:0]       err_code,
    output logic [CNT_W-1:0] cyc_full,
    output logic [CNT_W-1:0] cyc_short
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } mon_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mon_state_t       state, state_nxt;
    logic             code_legal, trans_ok;
    logic [1:0]       code_dec;
    logic             ev_lock, ev_ok, ev_err;
    logic [3:0]       prev_raw;

    logic [1:0]       state_dec_nxt;
    logic             in_est_nxt, in_est_vld_nxt, err_nxt;
    logic [7:0]       err_code_nxt;
    logic [CNT_W-1:0] cyc_full_nxt, cyc_short_nxt;

    // code_vld is a qualifier only: there is no back-pressure, a sample is taken on
    // every rising edge where code_vld is high and ignored otherwise.
    always_ff @(posedge clk) begin
        if (!reset) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        code_legal = 1'b1;
        code_dec   = 2'd0;
        case (code_in)
            4'b0000: code_dec = 2'd0;
            4'b0001: code_dec = 2'd1;
            4'b0010: code_dec = 2'd2;
            4'b0100: code_dec = 2'd3;
            default: code_legal = 1'b0;
        endcase

        trans_ok = 1'b0;
        case (state_dec)
            2'd0: trans_ok = (code_dec == 2'd1);
            2'd1: trans_ok = (code_dec == 2'd0) || (code_dec == 2'd2);
            2'd2: trans_ok = (code_dec == 2'd3);
            2'd3: trans_ok = (code_dec == 2'd0);
            default: trans_ok = 1'b0;
        endcase

        ev_lock = code_vld && (state == HUNT) && (code_in == 4'b0000);
        ev_ok   = code_vld && (state == LOCKED) && code_legal && trans_ok;
        ev_err  = code_vld && (state == LOCKED) && !(code_legal && trans_ok);

        state_nxt = state;
        if (ev_lock) state_nxt = LOCKED;
        if (ev_err)  state_nxt = HUNT;
    end

    // While locked, state_dec doubles as the previous sequencer state.
    always_comb begin
        prev_raw = (state_dec == 2'd3) ? 4'b0100 : {2'b00, state_dec};

        state_dec_nxt = state_dec;
        if (ev_lock) state_dec_nxt = 2'd0;
        if (ev_ok)   state_dec_nxt = code_dec;

        in_est_vld_nxt = ev_ok && (state_dec == 2'd1);
        in_est_nxt     = in_est_vld_nxt ? (code_dec == 2'd0) : in_est;

        cyc_short_nxt = cyc_short;
        if (ev_ok && (state_dec == 2'd1) && (code_dec == 2'd0) && (cyc_short != CNT_MAX))
            cyc_short_nxt = cyc_short + CNT_ONE;

        cyc_full_nxt = cyc_full;
        if (ev_ok && (state_dec == 2'd3) && (cyc_full != CNT_MAX))
            cyc_full_nxt = cyc_full + CNT_ONE;

        // A new error beats a simultaneous clear; otherwise the first error is kept.
        err_nxt      = err;
        err_code_nxt = err_code;
        if (err_clr) begin
            err_nxt      = 1'b0;
            err_code_nxt = 8'h00;
        end
        if (ev_err) begin
            err_nxt = 1'b1;
            if (!err || err_clr) err_code_nxt = {prev_raw, code_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_dec  <= 2'd0;
            in_est     <= 1'b0;
            in_est_vld <= 1'b0;
            err        <= 1'b0;
            err_code   <= 8'h00;
            cyc_full   <= '0;
            cyc_short  <= '0;
        end else begin
            state_dec  <= state_dec_nxt;
            in_est     <= in_est_nxt;
            in_est_vld <= in_est_vld_nxt;
            err        <= err_nxt;
            err_code   <= err_code_nxt;
            cyc_full   <= cyc_full_nxt;
            cyc_short  <= cyc_short_nxt;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_statem_monitor.sv
// Bench for statem_monitor: reference model feeds an expected queue per sampled edge,
// scenario tasks pop and compare; a second CNT_W=2 instance covers counter saturation.
module tb_statem_monitor;

    localparam int OW = 30;

    logic       clk = 1'b0;
    logic       reset, code_vld, err_clr;
    logic [3:0] code_in;
    logic       locked, in_est, in_est_vld, err;
    logic [1:0] state_dec;
    logic [7:0] err_code, cyc_full, cyc_short;

    logic       r2, v2, k2;
    logic [3:0] c2;
    logic       locked2, in_est2, in_est_vld2, err2;
    logic [1:0] state_dec2, cyc_full2, cyc_short2;
    logic [7:0] err_code2;

    logic [OW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic       m_locked, m_in_est, m_vld, m_err;
    logic [1:0] m_dec;
    logic [7:0] m_code, m_full, m_short;

    always #5 clk = ~clk;

    statem_monitor #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_vld(code_vld), .err_clr(err_clr),
        .locked(locked), .state_dec(state_dec), .in_est(in_est), .in_est_vld(in_est_vld),
        .err(err), .err_code(err_code), .cyc_full(cyc_full), .cyc_short(cyc_short)
    );

    statem_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(r2), .code_in(c2), .code_vld(v2), .err_clr(k2),
        .locked(locked2), .state_dec(state_dec2), .in_est(in_est2), .in_est_vld(in_est_vld2),
        .err(err2), .err_code(err_code2), .cyc_full(cyc_full2), .cyc_short(cyc_short2)
    );

    wire [OW-1:0] obs = {locked, state_dec, in_est, in_est_vld, err, err_code, cyc_full, cyc_short};

    function automatic logic legal_next(input logic [1:0] prev, input logic [3:0] code);
        case ({prev, code})
            6'b00_0001, 6'b01_0000, 6'b01_0010, 6'b10_0100, 6'b11_0000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] raw_of(input logic [1:0] s);
        case (s)
            2'd0: return 4'h0;
            2'd1: return 4'h1;
            2'd2: return 4'h2;
            default: return 4'h4;
        endcase
    endfunction

    task automatic model_update(input logic rst_n, input logic vld, input logic [3:0] code,
                                input logic clr);
        logic err_was;
        m_vld = 1'b0;
        if (!rst_n) begin
            m_locked = 0; m_dec = 0; m_in_est = 0; m_err = 0;
            m_code = 0; m_full = 0; m_short = 0;
        end else begin
            err_was = m_err;
            if (clr) begin
                m_err  = 1'b0;
                m_code = 8'h00;
            end
            if (vld) begin
                if (!m_locked) begin
                    if (code == 4'h0) begin
                        m_locked = 1'b1;
                        m_dec    = 2'd0;
                    end
                end else if (legal_next(m_dec, code)) begin
                    if (m_dec == 2'd1) begin
                        m_vld    = 1'b1;
                        m_in_est = (code == 4'h0);
                        if (code == 4'h0 && m_short != 8'hFF) m_short = m_short + 8'd1;
                    end
                    if (m_dec == 2'd3 && m_full != 8'hFF) m_full = m_full + 8'd1;
                    m_dec = (code == 4'h4) ? 2'd3 : code[1:0];
                end else begin
                    if (!err_was || clr) m_code = {raw_of(m_dec), code};
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end
            end
        end
    endtask

    // Driver: applies one sample, pushes the model's expected outputs, waits past the edge.
    task automatic step(input logic rst_n, input logic vld, input logic [3:0] code,
                        input logic clr);
        reset    = rst_n;
        code_vld = vld;
        code_in  = code;
        err_clr  = clr;
        model_update(rst_n, vld, code, clr);
        exp_q.push_back({m_locked, m_dec, m_in_est, m_vld, m_err, m_code, m_full, m_short});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [OW-1:0] e;
        step(1'b0, 1'b1, 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'h3, 1'b0);
        e = exp_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL reset_model: got %h expected %h", obs, e);
        else n_pass++;
        n_checks++;
        if (obs !== '0) $display("FAIL reset_zero: got %h expected %h", obs, {OW{1'b0}});
        else n_pass++;
    endtask

    task automatic test_full_cycle;
        logic [3:0] seq[5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h0};
        logic [OW-1:0] e;
        int pulses = 0;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, seq[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL full_cycle[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
            if (in_est_vld) begin
                pulses++;
                n_checks++;
                if (in_est !== 1'b0) $display("FAIL full_in_est: got %b expected 0", in_est);
                else n_pass++;
            end
            if (i == 0) begin
                n_checks++;
                if (locked !== 1'b1) $display("FAIL full_lock: got %b expected 1", locked);
                else n_pass++;
            end
        end
        n_checks++;
        if (cyc_full !== 8'd1 || err !== 1'b0 || pulses != 1)
            $display("FAIL full_summary: got cyc_full=%0d err=%b pulses=%0d expected 1 0 1",
                     cyc_full, err, pulses);
        else n_pass++;
    endtask

    task automatic test_short_cycle;
        logic [3:0] seq[3] = '{4'h0, 4'h1, 4'h0};
        logic [OW-1:0] e;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, seq[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL short_cycle[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        n_checks++;
        if (cyc_short !== 8'd1 || in_est !== 1'b1 || in_est_vld !== 1'b1 || state_dec !== 2'd0)
            $display("FAIL short_summary: got short=%0d in_est=%b vld=%b dec=%0d expected 1 1 1 0",
                     cyc_short, in_est, in_est_vld, state_dec);
        else n_pass++;
        step(1'b1, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        n_checks++;
        if (in_est_vld !== 1'b0 || in_est !== 1'b1)
            $display("FAIL short_pulse_end: got vld=%b in_est=%b expected 0 1", in_est_vld, in_est);
        else n_pass++;
    endtask

    task automatic test_error_sticky;
        // lock, reach two, illegal 0001, ignored junk in HUNT, relock, self-transition error
        logic [3:0] seq[8] = '{4'h0, 4'h1, 4'h2, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1};
        logic [OW-1:0] e;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, seq[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL error_seq[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
            if (i == 3) begin
                n_checks++;
                if (err !== 1'b1 || err_code !== 8'h21 || locked !== 1'b0 || state_dec !== 2'd2)
                    $display("FAIL error_first: got err=%b code=%h locked=%b dec=%0d expected 1 21 0 2",
                             err, err_code, locked, state_dec);
                else n_pass++;
            end
            if (i == 5) begin
                n_checks++;
                if (locked !== 1'b1) $display("FAIL error_relock: got %b expected 1", locked);
                else n_pass++;
            end
        end
        n_checks++;
        if (err_code !== 8'h21 || locked !== 1'b0)
            $display("FAIL error_keep: got code=%h locked=%b expected 21 0", err_code, locked);
        else n_pass++;
    endtask

    task automatic test_err_clr;
        // {vld, code, clr}: illegal 0011 with clr, clear, relock at two, 0000 error, clear+error
        logic [5:0] tbl[9] = '{6'b1_0000_0, 6'b1_0011_1, 6'b0_0000_1, 6'b1_0000_0,
                               6'b1_0001_0, 6'b1_0010_0, 6'b1_0000_0, 6'b1_0000_0,
                               6'b1_0011_1};
        logic [OW-1:0] e;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i][5], tbl[i][4:1], tbl[i][0]);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL err_clr_seq[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (err !== 1'b1 || err_code !== 8'h03)
                    $display("FAIL err_clr_win: got err=%b code=%h expected 1 03", err, err_code);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (err !== 1'b0 || err_code !== 8'h00)
                    $display("FAIL err_clr_clear: got err=%b code=%h expected 0 00", err, err_code);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if (err_code !== 8'h20 || locked !== 1'b0)
                    $display("FAIL two_zero_err: got code=%h locked=%b expected 20 0", err_code, locked);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gaps_and_mid_reset;
        // {vld, code}: gaps with junk codes between legal samples, then reset while at two
        logic [4:0] tbl[9] = '{5'b1_0000, 5'b0_0011, 5'b1_0001, 5'b0_1111, 5'b0_0000,
                               5'b1_0010, 5'b0_0001, 5'b0_0100, 5'b1_0100};
        logic [OW-1:0] e;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i][4], tbl[i][3:0], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL gaps[%0d]: got %h expected %h", i, obs, e);
            else n_pass++;
        end
        n_checks++;
        if (cyc_full !== 8'd0 || err !== 1'b0 || state_dec !== 2'd3)
            $display("FAIL gaps_state: got full=%0d err=%b dec=%0d expected 0 0 3",
                     cyc_full, err, state_dec);
        else n_pass++;
        step(1'b1, 1'b1, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h1, 1'b0);
        step(1'b1, 1'b1, 4'h2, 1'b0);
        step(1'b0, 1'b1, 4'h4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            if (i == 3) begin
                n_checks++;
                if (obs !== e || obs !== '0)
                    $display("FAIL mid_reset: got %h expected %h", obs, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] junk[6] = '{4'h3, 4'h8, 4'hF, 4'h5, 4'h6, 4'hC};
        logic [3:0] c;
        logic [OW-1:0] e;
        int bad = 0;
        step(1'b0, 1'b0, 4'h0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                if (!m_locked)            c = 4'h0;
                else if (m_dec == 2'd0)   c = 4'h1;
                else if (m_dec == 2'd1)   c = $urandom_range(0, 1) ? 4'h0 : 4'h2;
                else if (m_dec == 2'd2)   c = 4'h4;
                else                      c = 4'h0;
            end else if ($urandom_range(0, 1) == 0) begin
                c = junk[$urandom_range(0, 5)];
            end else begin
                c = raw_of(2'($urandom_range(0, 3)));
            end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), c,
                 ($urandom_range(0, 19) == 0));
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                if (bad < 10) $display("FAIL random[%0d]: got %h expected %h", i, obs, e);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_saturation;
        int exp_full;
        r2 = 1'b0; v2 = 1'b0; c2 = 4'h0; k2 = 1'b0;
        @(posedge clk); #1;
        r2 = 1'b1; v2 = 1'b1; c2 = 4'h0;
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            c2 = 4'h1; @(posedge clk); #1;
            c2 = 4'h2; @(posedge clk); #1;
            c2 = 4'h4; @(posedge clk); #1;
            c2 = 4'h0; @(posedge clk); #1;
            exp_full = (k > 3) ? 3 : k;
            n_checks++;
            if (cyc_full2 !== 2'(exp_full) || err2 !== 1'b0)
                $display("FAIL sat_full[%0d]: got %0d err=%b expected %0d 0", k, cyc_full2, err2, exp_full);
            else n_pass++;
        end
        for (int k = 1; k <= 4; k++) begin
            c2 = 4'h1; @(posedge clk); #1;
            c2 = 4'h0; @(posedge clk); #1;
        end
        n_checks++;
        if (cyc_short2 !== 2'b11 || cyc_full2 !== 2'b11)
            $display("FAIL sat_short: got short=%0d full=%0d expected 3 3", cyc_short2, cyc_full2);
        else n_pass++;
        v2 = 1'b0;
    endtask

    initial begin
        reset = 1'b0; code_vld = 1'b0; code_in = 4'h0; err_clr = 1'b0;
        r2 = 1'b0; v2 = 1'b0; c2 = 4'h0; k2 = 1'b0;
        m_locked = 0; m_dec = 0; m_in_est = 0; m_vld = 0; m_err = 0;
        m_code = 0; m_full = 0; m_short = 0;
        #2;
        test_reset();
        test_full_cycle();
        test_short_cycle();
        test_error_sticky();
        test_err_clr();
        test_gaps_and_mid_reset();
        test_random();
        test_saturation();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
